// File: rtl/dot_product_scheduler.sv
// Round-robin scheduler sharing one dot-product unit among NREQ requesters.
// Define DOTSCHED_FIXED_PRIO_EN for fixed priority (lowest index wins).
module dot_product_scheduler #(
  parameter int VLEN    = 5,
  parameter int NREQ    = 4,
  parameter int LATENCY = 4,
  localparam int ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*32*VLEN-1:0]  a_in,
  input  logic [NREQ*32*VLEN-1:0]  b_in,
  output logic [NREQ-1:0]          gnt,
  output logic                     busy,
  output logic [32*VLEN-1:0]       dp_a,
  output logic [32*VLEN-1:0]       dp_b,
  output logic                     dp_start,
  input  logic [31:0]              dp_result,
  output logic [31:0]              result,
  output logic                     result_valid,
  output logic [ID_W-1:0]          result_id
);

  localparam int OPW   = 32 * VLEN;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [ID_W-1:0] owner;
  logic [ID_W-1:0] win;
  logic            win_vld;
  logic [CNT_W-1:0] cnt;
  logic            load;
  logic            done;

`ifdef DOTSCHED_FIXED_PRIO_EN
  // Lowest set request index wins.
  always_comb begin
    win = '0;
    win_vld = |req;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) win = i[ID_W-1:0];
    end
  end
`else
  logic [ID_W-1:0] rr_ptr;
  int              idx;

  // Search upward from the slot after the last winner, wrapping.
  always_comb begin
    win = '0;
    win_vld = 1'b0;
    idx = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!win_vld && req[idx]) begin
        win = idx[ID_W-1:0];
        win_vld = 1'b1;
      end
    end
  end

  // Last winner becomes the new search origin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= ID_W'(NREQ - 1);
    end else if (load) begin
      rr_ptr <= win;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus the load/done strobes.
  always_comb begin
    state_nxt = state;
    load = 1'b0;
    done = 1'b0;
    unique case (state)
      IDLE: begin
        if (win_vld) begin
          load = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          done = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, latency count and result return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt          <= '0;
      busy         <= 1'b0;
      dp_a         <= '0;
      dp_b         <= '0;
      dp_start     <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      result_id    <= '0;
      owner        <= '0;
      cnt          <= '0;
    end else begin
      gnt          <= '0;
      dp_start     <= 1'b0;
      result_valid <= 1'b0;
      if (load) begin
        gnt      <= NREQ'(1) << win;
        dp_start <= 1'b1;
        dp_a     <= a_in[OPW*int'(win) +: OPW];
        dp_b     <= b_in[OPW*int'(win) +: OPW];
        owner    <= win;
        cnt      <= CNT_W'(LATENCY - 1);
        busy     <= 1'b1;
      end else if (done) begin
        result       <= dp_result;
        result_id    <= owner;
        result_valid <= 1'b1;
        busy         <= 1'b0;
      end else if (state == BUSY) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dot_product_scheduler.sv
// Scoreboard bench for dot_product_scheduler.
// Shared unit modelled as a real-valued dot product pipeline.
module tb_dot_product_scheduler;

  localparam int VLEN = 5;
  localparam int NREQ = 4;
  localparam int LAT  = 4;
  localparam int ID_W = 2;
  localparam int OPW  = 32 * VLEN;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*OPW-1:0]  a_in = '0;
  logic [NREQ*OPW-1:0]  b_in = '0;
  logic [NREQ-1:0]      gnt;
  logic                 busy;
  logic [OPW-1:0]       dp_a;
  logic [OPW-1:0]       dp_b;
  logic                 dp_start;
  logic [31:0]          dp_result;
  logic [31:0]          result;
  logic                 result_valid;
  logic [ID_W-1:0]      result_id;

  dot_product_scheduler #(.VLEN(VLEN), .NREQ(NREQ), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .busy(busy), .dp_a(dp_a), .dp_b(dp_b),
    .dp_start(dp_start), .dp_result(dp_result), .result(result),
    .result_valid(result_valid), .result_id(result_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ID_W-1:0] id;
    real             val;
    real             tol;
  } exp_t;

  exp_t            sb[$];
  logic [NREQ-1:0] gq[$];
  int              gcyc[$];
  int              cyc = 0;
  int              total = 0;
  int              bad = 0;

  function automatic real f2r(logic [31:0] b);
    real v;
    int  e;
    e = int'(b[30:23]);
    if (e == 0) return 0.0;
    v = 1.0 + real'(b[22:0]) / 8388608.0;
    for (int i = 0; i < e - 127; i++) v = v * 2.0;
    for (int i = 0; i < 127 - e; i++) v = v / 2.0;
    return b[31] ? -v : v;
  endfunction

  function automatic logic [31:0] r2f(real r);
    real         a;
    int          e;
    int          m;
    logic [31:0] o;
    if (r == 0.0) return 32'h0;
    a = (r < 0.0) ? -r : r;
    e = 127;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    m = $rtoi((a - 1.0) * 8388608.0 + 0.5);
    if (m >= 8388608) begin m = 0; e++; end
    o = {(r < 0.0), e[7:0], m[22:0]};
    return o;
  endfunction

  function automatic real dotr(logic [OPW-1:0] a, logic [OPW-1:0] b);
    real s;
    s = 0.0;
    for (int k = 0; k < VLEN; k++) s = s + f2r(a[32*k +: 32]) * f2r(b[32*k +: 32]);
    return s;
  endfunction

  function automatic void chk(string nm, logic [OPW-1:0] act, logic [OPW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  function automatic void chkr(string nm, real act, real exp, real tol);
    real d;
    total++;
    d = act - exp;
    if (d < 0.0) d = -d;
    if (d > tol) begin
      bad++;
      $display("FAIL %s: got %g want %g", nm, act, exp);
    end
  endfunction

  // Shared unit model: computes on dp_start, result emerges LAT edges after load.
  logic [31:0] pipe [LAT-1];
  assign dp_result = pipe[LAT-2];

  always @(posedge clk) begin
    if (dp_start) pipe[0] <= r2f(dotr(dp_a, dp_b));
    for (int k = 1; k < LAT - 1; k++) pipe[k] <= pipe[k-1];
  end

  exp_t mon_e;
  int   mon_g;

  // Monitor: grants and results compared against the scoreboard queues.
  always @(negedge clk) begin
    if (rst_n) begin
      cyc++;
      if (gnt != '0) begin
        chk("dp_start_with_gnt", OPW'(dp_start), OPW'(1));
        if (gq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_gnt: got %b want none", gnt);
        end else begin
          chk("gnt_order", OPW'(gnt), OPW'(gq.pop_front()));
        end
        gcyc.push_back(cyc);
      end else if (dp_start) begin
        chk("dp_start_without_gnt", OPW'(dp_start), OPW'(0));
      end
      if (result_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got id %0d val %h want none", result_id, result);
        end else begin
          mon_e = sb.pop_front();
          chk("result_id", OPW'(result_id), OPW'(mon_e.id));
          chkr("result_val", f2r(result), mon_e.val, mon_e.tol);
        end
        if (gcyc.size() == 0) begin
          total++;
          bad++;
          $display("FAIL latency: got result with no grant want grant first");
        end else begin
          mon_g = gcyc.pop_front();
          chk("latency", OPW'(cyc - mon_g), OPW'(LAT));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output int c);
    c = -1;
    for (int k = 0; k < 20 && c < 0; k++) begin
      @(posedge clk);
      #1;
      if (gnt != '0) c = cyc;
    end
    if (c < 0) begin
      total++;
      bad++;
      $display("FAIL gnt_timeout: got no gnt want gnt within 20 cycles");
    end
  endtask

  task automatic flush();
    sb.delete();
    gq.delete();
    gcyc.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush();
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic set_uni(input int i, input logic [31:0] av, input logic [31:0] bv);
    for (int k = 0; k < VLEN; k++) begin
      a_in[i*OPW + 32*k +: 32] = av;
      b_in[i*OPW + 32*k +: 32] = bv;
    end
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_gnt"}, OPW'(gnt), '0);
    chk({tag, "_busy"}, OPW'(busy), '0);
    chk({tag, "_dp_a"}, dp_a, '0);
    chk({tag, "_dp_b"}, dp_b, '0);
    chk({tag, "_dp_start"}, OPW'(dp_start), '0);
    chk({tag, "_result"}, OPW'(result), '0);
    chk({tag, "_result_valid"}, OPW'(result_valid), '0);
    chk({tag, "_result_id"}, OPW'(result_id), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int             c;
    int             prev;
    int             seen;
    real            va [VLEN];
    real            vb [VLEN];
    logic [OPW-1:0] pa;
    logic [OPW-1:0] pb;
    real            ex;

    // 1: reset values, then idle with no requests
    #12;
    chk_zero("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (gnt != '0 || busy) seen++;
    end
    chk("idle_no_gnt", OPW'(seen), '0);

    // 2: single requester 1, 5 x 1.0 . 2.0 = 10.0
    set_uni(1, 32'h3F800000, 32'h40000000);
    gq.push_back(4'b0010);
    sb.push_back('{2'd1, 10.0, 0.0});
    req = 4'b0010;
    wait_gnt(c);
    req = '0;
    tick(LAT + 2);
    chk("t2_result_bits", OPW'(result), OPW'(32'h41200000));
    chk("t2_busy_low", OPW'(busy), '0);

    // 3: all requesting, four distinct results
    do_reset();
    for (int i = 0; i < NREQ; i++) set_uni(i, r2f(real'(i + 1)), 32'h3F800000);
    for (int g = 0; g < 5; g++) begin
`ifdef DOTSCHED_FIXED_PRIO_EN
      gq.push_back(4'b0001);
      sb.push_back('{2'd0, 5.0, 0.0});
`else
      gq.push_back(4'b0001 << (g % NREQ));
      sb.push_back('{2'(g % NREQ), 5.0 * real'((g % NREQ) + 1), 0.0});
`endif
    end
    req = 4'b1111;
    prev = 0;
    for (int g = 0; g < 5; g++) begin
      wait_gnt(c);
      if (g > 0) chk("t3_spacing", OPW'(c - prev), OPW'(LAT + 1));
      prev = c;
    end
    req = '0;
    tick(LAT + 2);

    // 4: mixed-sign operands on requester 2, operands held while busy
    va = '{3.2, 0.66, -0.5, -0.5, 2.82};
    vb = '{4.2, 0.51, -6.4, 6.4, -0.94};
    ex = 0.0;
    for (int k = 0; k < VLEN; k++) begin
      pa[32*k +: 32] = r2f(va[k]);
      pb[32*k +: 32] = r2f(vb[k]);
      ex = ex + f2r(r2f(va[k])) * f2r(r2f(vb[k]));
    end
    a_in[2*OPW +: OPW] = pa;
    b_in[2*OPW +: OPW] = pb;
    gq.push_back(4'b0100);
    sb.push_back('{2'd2, ex, 1.0 / 1048576.0});
    req = 4'b0100;
    wait_gnt(c);
    req = '0;
    a_in[2*OPW +: OPW] = {VLEN{32'hDEADBEEF}};
    b_in[2*OPW +: OPW] = {VLEN{32'h12345678}};
    for (int k = 0; k <= LAT; k++) begin
      chk("t4_dp_a_hold", dp_a, pa);
      chk("t4_dp_b_hold", dp_b, pb);
      tick(1);
    end
    tick(1);

    // 5: reset two cycles into an operation drops it
    set_uni(3, 32'h3F800000, r2f(3.0));
    gq.push_back(4'b1000);
    sb.push_back('{2'd3, 15.0, 0.0});
    req = 4'b1000;
    wait_gnt(c);
    req = '0;
    tick(2);
    rst_n = 1'b0;
    #1;
    chk_zero("mid_rst");
    flush();
    tick(2);
    rst_n = 1'b1;
    tick(LAT + 3);
    gq.push_back(4'b1000);
    sb.push_back('{2'd3, 15.0, 0.0});
    req = 4'b1000;
    wait_gnt(c);
    req = '0;
    tick(LAT + 2);
    chk("t5_result_bits", OPW'(result), OPW'(32'h41700000));

`ifdef DOTSCHED_FIXED_PRIO_EN
    // 6: fixed priority starves requester 3
    for (int g = 0; g < 4; g++) begin
      gq.push_back(4'b0010);
      sb.push_back('{2'd1, 10.0, 0.0});
    end
    req = 4'b1010;
    for (int g = 0; g < 4; g++) wait_gnt(c);
    req = '0;
    tick(LAT + 2);
`endif

    chk("sb_drained", OPW'(sb.size()), '0);
    chk("gq_drained", OPW'(gq.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
